// File: rtl/amber_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// amber_wb_cmd_master
//
// Wishbone classic-cycle initiator for Amber slave peripherals. A front end
// hands over one register command at a time (address, data, byte selects,
// direction). The block runs exactly one Wishbone cycle for that command and
// then returns read data and an error flag. Every bus cycle has a timeout, so
// a slave that never answers still produces an error response instead of
// hanging the front end.
//
// Parameters
//   WB_DWIDTH       bus data width, 32 or 128
//   WB_SWIDTH       bus select width, WB_DWIDTH/8
//   TIMEOUT_CYCLES  maximum number of cycles stb is held without ack/err (1..255)
//
// Ports
//   i_clk, i_rst_n            clock; asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready   command handshake
//   i_cmd_we/adr/dat/sel      command direction, byte address, write data,
//                             byte enables within the 32-bit word
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_dat/o_rsp_err       read data (0 for writes and errors), error flag
//   o_wb_*                    Wishbone initiator outputs
//   i_wb_dat/ack/err          Wishbone slave returns
// -----------------------------------------------------------------------------
module amber_wb_cmd_master #(
    parameter int WB_DWIDTH      = 32,
    parameter int WB_SWIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,

    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_we,
    input  logic [31:0]          i_cmd_adr,
    input  logic [31:0]          i_cmd_dat,
    input  logic [3:0]           i_cmd_sel,

    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_dat,
    output logic                 o_rsp_err,

    output logic [31:0]          o_wb_adr,
    output logic [WB_SWIDTH-1:0] o_wb_sel,
    output logic                 o_wb_we,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Counter value on the last permitted strobe cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]           state_reg;
    logic [7:0]           tmo_cnt_reg;
    logic                 wb_we_reg;
    logic [31:0]          wb_adr_reg;
    logic [WB_SWIDTH-1:0] wb_sel_reg;
    logic [WB_DWIDTH-1:0] wb_dat_reg;
    logic [31:0]          rsp_dat_reg;
    logic                 rsp_err_reg;

    // Lane steering: the select pattern to register at command accept, and
    // the 32-bit read lane addressed by the registered command.
    logic [WB_SWIDTH-1:0] wb_sel_next;
    logic [31:0]          rd_lane;

    generate
        if (WB_DWIDTH == 128) begin : g_w128
            logic [31:0] lanes [4];
            for (genvar gi = 0; gi < 4; gi++) begin : g_lane
                assign lanes[gi] = i_wb_dat[32*gi +: 32];
            end
            assign rd_lane     = lanes[wb_adr_reg[3:2]];
            // Word k of the 128-bit beat owns select bits [4k+3:4k].
            assign wb_sel_next = WB_SWIDTH'(i_cmd_sel) << {i_cmd_adr[3:2], 2'b00};
        end else begin : g_w32
            assign rd_lane     = i_wb_dat[31:0];
            assign wb_sel_next = WB_SWIDTH'(i_cmd_sel);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            tmo_cnt_reg <= '0;
            wb_we_reg   <= 1'b0;
            wb_adr_reg  <= '0;
            wb_sel_reg  <= '0;
            wb_dat_reg  <= '0;
            rsp_dat_reg <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        wb_we_reg   <= i_cmd_we;
                        wb_adr_reg  <= i_cmd_adr;
                        wb_sel_reg  <= wb_sel_next;
                        // Write data is replicated on every 32-bit lane; the
                        // select pattern picks the lane the slave uses.
                        wb_dat_reg  <= {(WB_DWIDTH/32){i_cmd_dat}};
                        tmo_cnt_reg <= '0;
                        state_reg   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    if (i_wb_err) begin
                        // err wins over a simultaneous ack
                        rsp_err_reg <= 1'b1;
                        rsp_dat_reg <= '0;
                        state_reg   <= ST_RESP;
                    end else if (i_wb_ack) begin
                        rsp_err_reg <= 1'b0;
                        rsp_dat_reg <= wb_we_reg ? 32'd0 : rd_lane;
                        state_reg   <= ST_RESP;
                    end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
                        rsp_err_reg <= 1'b1;
                        rsp_dat_reg <= '0;
                        state_reg   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Handshake and bus-cycle strobes decode from state only, so no slave
    // input ever reaches an output combinationally.
    assign o_cmd_ready = (state_reg == ST_IDLE);
    assign o_wb_cyc    = (state_reg == ST_BUS);
    assign o_wb_stb    = (state_reg == ST_BUS);
    assign o_rsp_valid = (state_reg == ST_RESP);

    assign o_wb_adr    = wb_adr_reg;
    assign o_wb_sel    = wb_sel_reg;
    assign o_wb_we     = wb_we_reg;
    assign o_wb_dat    = wb_dat_reg;
    assign o_rsp_dat   = rsp_dat_reg;
    assign o_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_amber_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// Testbench for amber_wb_cmd_master. Two instances share one clock:
//   dut_a : 32-bit bus, TIMEOUT_CYCLES=16
//   dut_b : 128-bit bus, TIMEOUT_CYCLES=16, with its own reset
// Each has a small slave whose reply (ack/err/both/none, delay, data) is
// chosen per command. Expected responses come from the command and the chosen
// slave behaviour alone.
// -----------------------------------------------------------------------------
module tb_amber_wb_cmd_master;

    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: 32-bit ----------------
    logic        a_rst_n, a_cmd_valid, a_cmd_ready, a_cmd_we;
    logic [31:0] a_cmd_adr, a_cmd_dat;
    logic [3:0]  a_cmd_sel;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_dat;
    logic [31:0] a_wb_adr, a_wb_dat, a_wb_rdat;
    logic [3:0]  a_wb_sel;
    logic        a_wb_we, a_wb_cyc, a_wb_stb, a_wb_ack, a_wb_err;

    amber_wb_cmd_master #(.WB_DWIDTH(32), .WB_SWIDTH(4), .TIMEOUT_CYCLES(TMO)) dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n),
        .i_cmd_valid(a_cmd_valid), .o_cmd_ready(a_cmd_ready), .i_cmd_we(a_cmd_we),
        .i_cmd_adr(a_cmd_adr), .i_cmd_dat(a_cmd_dat), .i_cmd_sel(a_cmd_sel),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
        .o_rsp_dat(a_rsp_dat), .o_rsp_err(a_rsp_err),
        .o_wb_adr(a_wb_adr), .o_wb_sel(a_wb_sel), .o_wb_we(a_wb_we), .o_wb_dat(a_wb_dat),
        .o_wb_cyc(a_wb_cyc), .o_wb_stb(a_wb_stb),
        .i_wb_dat(a_wb_rdat), .i_wb_ack(a_wb_ack), .i_wb_err(a_wb_err)
    );

    // slave A: kind 0=ack, 1=err, 2=ack+err, 3=silent; replies on strobe cycle a_delay
    int a_kind = 3, a_delay = 0, a_scnt = 0;
    always @(posedge clk) a_scnt <= a_wb_stb ? a_scnt + 1 : 0;
    assign a_wb_ack = a_wb_stb && (a_kind == 0 || a_kind == 2) && (a_scnt == a_delay);
    assign a_wb_err = a_wb_stb && (a_kind == 1 || a_kind == 2) && (a_scnt == a_delay);

    // ---------------- instance B: 128-bit ----------------
    logic         b_rst_n, b_cmd_valid, b_cmd_ready, b_cmd_we;
    logic [31:0]  b_cmd_adr, b_cmd_dat;
    logic [3:0]   b_cmd_sel;
    logic         b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0]  b_rsp_dat, b_wb_adr;
    logic [127:0] b_wb_dat, b_wb_rdat;
    logic [15:0]  b_wb_sel;
    logic         b_wb_we, b_wb_cyc, b_wb_stb, b_wb_ack, b_wb_err;

    amber_wb_cmd_master #(.WB_DWIDTH(128), .WB_SWIDTH(16), .TIMEOUT_CYCLES(TMO)) dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n),
        .i_cmd_valid(b_cmd_valid), .o_cmd_ready(b_cmd_ready), .i_cmd_we(b_cmd_we),
        .i_cmd_adr(b_cmd_adr), .i_cmd_dat(b_cmd_dat), .i_cmd_sel(b_cmd_sel),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
        .o_rsp_dat(b_rsp_dat), .o_rsp_err(b_rsp_err),
        .o_wb_adr(b_wb_adr), .o_wb_sel(b_wb_sel), .o_wb_we(b_wb_we), .o_wb_dat(b_wb_dat),
        .o_wb_cyc(b_wb_cyc), .o_wb_stb(b_wb_stb),
        .i_wb_dat(b_wb_rdat), .i_wb_ack(b_wb_ack), .i_wb_err(b_wb_err)
    );

    int b_delay = 0, b_scnt = 0;
    logic b_silent = 1'b0;
    always @(posedge clk) b_scnt <= b_wb_stb ? b_scnt + 1 : 0;
    assign b_wb_ack = b_wb_stb && !b_silent && (b_scnt == b_delay);
    assign b_wb_err = 1'b0;

    // ---------------- A transaction ----------------
    task automatic run_a(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int kind, input int delay,
                         input logic [31:0] rdat, input int bp);
        int n;
        int exp_n;
        logic exp_err;
        logic [31:0] exp_dat;
        logic responded;
        responded = (kind != 3) && (delay < TMO);
        exp_n   = responded ? delay + 1 : TMO;
        exp_err = !responded || (kind != 0);
        exp_dat = (exp_err || we) ? 32'd0 : rdat;

        a_kind = kind; a_delay = delay; a_wb_rdat = rdat;
        chk("a_cmd_ready_idle", a_cmd_ready, 1'b1);
        a_cmd_valid = 1'b1; a_cmd_we = we; a_cmd_adr = adr; a_cmd_dat = dat; a_cmd_sel = sel;
        @(posedge clk); #1;
        a_cmd_valid = 1'b0; a_cmd_adr = 32'hDEAD_BEEF; a_cmd_dat = 32'h0BAD_F00D;
        chk("a_cyc_start", a_wb_cyc, 1'b1);
        chk("a_cmd_ready_bus", a_cmd_ready, 1'b0);
        chk("a_wb_adr", a_wb_adr, adr);
        chk("a_wb_we", a_wb_we, we);
        chk("a_wb_sel", a_wb_sel, sel);
        chk("a_wb_dat", a_wb_dat, dat);
        n = 0;
        while (a_wb_stb === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("a_stb_cycles", n, exp_n);
        chk("a_cyc_end", a_wb_cyc, 1'b0);
        chk("a_rsp_valid", a_rsp_valid, 1'b1);
        chk("a_rsp_err", a_rsp_err, exp_err);
        chk("a_rsp_dat", a_rsp_dat, exp_dat);
        // hold off the response while a new command is waiting
        a_cmd_valid = (bp > 0);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("a_bp_valid", a_rsp_valid, 1'b1);
            chk("a_bp_dat", a_rsp_dat, exp_dat);
            chk("a_bp_err", a_rsp_err, exp_err);
            chk("a_bp_ready", a_cmd_ready, 1'b0);
            chk("a_bp_cyc", a_wb_cyc, 1'b0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        a_cmd_valid = 1'b0;
        chk("a_rsp_done", a_rsp_valid, 1'b0);
        chk("a_ready_after", a_cmd_ready, 1'b1);
        chk("a_cyc_idle", a_wb_cyc, 1'b0);
        $display("A we=%0b adr=%08h kind=%0d delay=%0d bp=%0d stb=%0d err=%0b dat=%08h",
                 we, adr, kind, delay, bp, n, a_rsp_err, a_rsp_dat);
    endtask

    // ---------------- B transaction ----------------
    task automatic run_b(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int delay, input logic [127:0] rdat);
        int n;
        int k;
        logic [15:0] exp_sel;
        logic [31:0] exp_dat;
        k = int'(adr[3:2]);
        exp_sel = 16'(sel) << (4 * k);
        exp_dat = we ? 32'd0 : rdat[32*k +: 32];

        b_delay = delay; b_wb_rdat = rdat; b_silent = 1'b0;
        chk("b_cmd_ready_idle", b_cmd_ready, 1'b1);
        b_cmd_valid = 1'b1; b_cmd_we = we; b_cmd_adr = adr; b_cmd_dat = dat; b_cmd_sel = sel;
        @(posedge clk); #1;
        b_cmd_valid = 1'b0;
        chk("b_cyc_start", b_wb_cyc, 1'b1);
        chk("b_wb_adr", b_wb_adr, adr);
        chk("b_wb_sel", b_wb_sel, exp_sel);
        chk("b_wb_dat", b_wb_dat, {4{dat}});
        n = 0;
        while (b_wb_stb === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("b_stb_cycles", n, delay + 1);
        chk("b_rsp_valid", b_rsp_valid, 1'b1);
        chk("b_rsp_err", b_rsp_err, 1'b0);
        chk("b_rsp_dat", b_rsp_dat, exp_dat);
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;
        chk("b_rsp_done", b_rsp_valid, 1'b0);
        $display("B we=%0b adr=%08h sel=%04h delay=%0d dat=%08h", we, adr, b_wb_sel, delay, b_rsp_dat);
    endtask

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_cmd_valid = 0; a_cmd_we = 0; a_cmd_adr = 0; a_cmd_dat = 0; a_cmd_sel = 0;
        a_rsp_ready = 0; a_wb_rdat = 0;
        b_cmd_valid = 0; b_cmd_we = 0; b_cmd_adr = 0; b_cmd_dat = 0; b_cmd_sel = 0;
        b_rsp_ready = 0; b_wb_rdat = 0;
        #3;
        chk("rst_cyc", a_wb_cyc, 1'b0);
        chk("rst_stb", a_wb_stb, 1'b0);
        chk("rst_we", a_wb_we, 1'b0);
        chk("rst_adr", a_wb_adr, 32'd0);
        chk("rst_sel", a_wb_sel, 4'd0);
        chk("rst_dat", a_wb_dat, 32'd0);
        chk("rst_rsp_valid", a_rsp_valid, 1'b0);
        chk("rst_rsp_err", a_rsp_err, 1'b0);
        chk("rst_rsp_dat", a_rsp_dat, 32'd0);
        chk("rst_b_sel", b_wb_sel, 16'd0);
        #20 a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", a_cmd_ready, 1'b1);

        // directed cases
        run_a(1'b1, 32'h8, 32'hFF, 4'hF, 0, 0, 32'hCAFE_0001, 0);   // same-cycle ack write
        run_a(1'b0, 32'h8, 32'h0, 4'hF, 0, 1, 32'h0000_00FF, 0);    // late ack read
        run_a(1'b0, 32'h10, 32'h0, 4'hF, 3, 0, 32'h1111_2222, 0);   // timeout
        run_a(1'b1, 32'h14, 32'h55, 4'h3, 0, 0, 32'h0, 0);          // accepted after timeout
        run_a(1'b0, 32'h18, 32'h0, 4'hF, 2, 0, 32'h1234_5678, 0);   // err+ack together
        run_a(1'b0, 32'h1C, 32'h0, 4'hF, 0, 2, 32'h89AB_CDEF, 5);   // backpressure

        // random commands against A
        for (int i = 0; i < 40; i++) begin
            run_a(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 19), $urandom, $urandom_range(0, 3));
        end

        // 128-bit: directed top-lane read, then random
        run_b(1'b0, 32'hC, 32'h0, 4'hF, 0, {32'hA5A5_0003, 96'd0});
        for (int i = 0; i < 20; i++) begin
            run_b(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), {$urandom, $urandom, $urandom, $urandom});
        end

        // reset in the middle of a bus cycle on B
        b_silent = 1'b1;
        b_cmd_valid = 1'b1; b_cmd_we = 1'b0; b_cmd_adr = 32'h4; b_cmd_sel = 4'hF;
        @(posedge clk); #1;
        b_cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b_mid_cyc", b_wb_cyc, 1'b1);
        #1 b_rst_n = 1'b0;
        #1;
        chk("b_rst_cyc", b_wb_cyc, 1'b0);
        chk("b_rst_stb", b_wb_stb, 1'b0);
        chk("b_rst_rsp", b_rsp_valid, 1'b0);
        @(posedge clk); #3 b_rst_n = 1'b1;
        b_silent = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("b_post_rsp", b_rsp_valid, 1'b0);
            chk("b_post_cyc", b_wb_cyc, 1'b0);
        end
        chk("b_post_ready", b_cmd_ready, 1'b1);
        $display("B reset mid-bus: rsp_valid=%0b cyc=%0b", b_rsp_valid, b_wb_cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
